pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the stall and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, including stallEX and flushEX on EX/MEM.
- Handles load-use hazards, taken-branch squash, multi-cycle data-memory access and halt drain-to-stop.

Parameters:
- MEM_LAT, 2, extra cycles a data-memory access holds the pipeline (0 = single-cycle memory, never stalls)
- ADDR_W, 4, register-address width
- CNT_W, 4, wait-counter width; MEM_LAT must be < 2^CNT_W

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- srcA_ID  in  ADDR_W  source A register of the instruction in ID
- srcA_useID  in  1  instruction in ID reads srcA
- srcB_ID  in  ADDR_W  source B register of the instruction in ID
- srcB_useID  in  1  instruction in ID reads srcB
- dst_addrEX  in  ADDR_W  destination of the instruction in EX
- weEX  in  1  EX instruction writes the register file
- mem_reEX  in  1  EX instruction is a load
- branch_takenEX  in  1  branch in EX resolved taken
- mem_reqMEM  in  1  MEM instruction accesses data memory (read or write)
- hltID  in  1  halt opcode decoded in ID
- hltWB  in  1  halt instruction in WB
- stallPC, stallIF, stallID, stallEX  out  1 each  hold PC, IF/ID, ID/EX, EX/MEM
- flushIF  out  1  load bubble into IF/ID
- flushID  out  1  load bubble into ID/EX
- flushMEM  out  1  load bubble into MEM/WB
- flushEX  out  1  load bubble into EX/MEM; tied 0 (reserved)
- halted  out  1  registered; processor stopped

Behaviour:
- State:
  - FSM {RUN, MEM_WAIT, HALTED}
  - cnt[CNT_W-1:0]
  - halt_pend flag
  - Reset: RUN, cnt=0, halt_pend=0, halted=0.
  - While rst=1, every output is 0.
- Outputs are combinational from state and inputs, except halted.
- memhold = (RUN && mem_reqMEM && MEM_LAT!=0) || (MEM_WAIT && cnt!=0).
  - When memhold=1: stallPC, stallIF, stallID, stallEX = 1; flushMEM=1; flushIF=flushID=0.
  - Branch, load-use and halt-detect are all suppressed while memhold=1.
  - The branch and load-use inputs remain valid because the upstream stages are held; they are acted on once memhold clears.
- Memory FSM:
  - RUN with mem_reqMEM=1 and MEM_LAT!=0: go to MEM_WAIT, cnt<=MEM_LAT-1.
  - MEM_WAIT with cnt!=0: cnt<=cnt-1.
  - MEM_WAIT with cnt==0: no stall this cycle; the instruction advances; go to RUN.
  - Net effect: exactly MEM_LAT stall cycles per access. Back-to-back accesses each incur MEM_LAT.
  - A new request is not recognised in the exit cycle; the next MEM instruction is sampled in RUN.
- Branch (memhold=0): branch_takenEX=1 gives flushIF=1 and flushID=1. Branch takes priority over load-use (the dependent instruction is squashed anyway).
- Load-use (memhold=0, no branch):
  - Condition: mem_reEX && weEX && dst_addrEX!=0 && ((srcA_useID && srcA_ID==dst_addrEX) || (srcB_useID && srcB_ID==dst_addrEX)).
  - Response: stallPC=stallIF=stallID=1 and flushID=1 for one cycle. The next cycle the load has left EX, so the condition clears.
- Halt:
  - hltID=1 with memhold=0, no branch and halt_pend=0 sets halt_pend.
  - While halt_pend=1: stallPC=1 and flushIF=1 every cycle (no further fetch).
  - hltWB=1 (and not in MEM_WAIT) moves to HALTED.
- HALTED:
  - All stalls=1, all flushes=0, halted<=1.
  - Absorbing state; only rst exits.
- Simultaneous events:
  - Memory wait outranks branch, which outranks load-use.
  - A branch in EX in the same cycle as hltID squashes the halt; halt_pend is not set.
- Reset mid-wait: state, cnt and halt_pend clear immediately (asynchronously); outputs go to 0.

Decomposition:
- Shared package pipe_pkg holds:
  - FSM state encoding (RUN=2'd0, MEM_WAIT=2'd1, HALTED=2'd2)
  - ADDR_W and register-0 constant REG_ZERO
  - stall/flush bundle field order, shared with all pipeline registers
- Natural sub-module: hazard_detect (combinational load-use compare). The FSM, counter and priority mux stay in the top.

Test Plan:
- MEM_LAT=2, one-cycle pulse mem_reqMEM=1 in RUN -> stallEX=1 and flushMEM=1 for exactly 2 cycles, then 0; state back in RUN on the 3rd cycle.
- Load r3 in EX (mem_reEX=1, weEX=1, dst=3), srcB_ID=3 with use=1 -> one cycle of stallPC/IF/ID=1 and flushID=1. Repeat with dst=0 -> no stall.
- branch_takenEX=1 together with load-use condition -> flushIF=flushID=1, stallPC=0.
- branch_takenEX=1 during MEM_WAIT (cnt=1) -> no flush until the exit cycle, where flushIF=flushID=1.
- hltID=1 -> stallPC=flushIF=1 from the next cycle; hltWB=1 three cycles later -> halted=1 on the next edge, all stalls=1, persistent for 10+ cycles.
- rst asserted mid-MEM_WAIT -> all outputs 0 immediately; after release, mem_reqMEM=0 gives no stall.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard sequencer and the pipeline registers.
// The stall/flush bundle field order is common to every pipeline register.
package pipe_pkg;

  localparam int ADDR_W = 4;
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTED   = 2'd2
  } hazState_t;

  typedef struct packed {
    logic stallPC;
    logic stallIF;
    logic stallID;
    logic stallEX;
    logic flushIF;
    logic flushID;
    logic flushEX;
    logic flushMEM;
  } pipeCtrl_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination is read
// by the instruction in ID. Register 0 never creates a dependency.
module hazard_detect
  import pipe_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic [ADDR_W-1:0] srcA,
  input  logic              srcAUse,
  input  logic [ADDR_W-1:0] srcB,
  input  logic              srcBUse,
  input  logic [ADDR_W-1:0] dstAddr,
  input  logic              we,
  input  logic              memRe,
  output logic              loadUse
);

  logic [ADDR_W-1:0] srcAddr [2];
  logic [1:0]        srcUse;
  logic [1:0]        srcMatch;

  assign srcAddr[0] = srcA;
  assign srcAddr[1] = srcB;
  assign srcUse     = {srcBUse, srcAUse};

  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    assign srcMatch[gi] = srcUse[gi] && (srcAddr[gi] == dstAddr);
  end

  assign loadUse = memRe && we && (dstAddr != ADDR_W'(REG_ZERO)) && (|srcMatch);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory wait, branch squash,
// load-use bubble and halt drain. Priority: halted > memory wait > branch > load-use.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int ADDR_W  = 4,
  parameter int CNT_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] srcA_ID,
  input  logic              srcA_useID,
  input  logic [ADDR_W-1:0] srcB_ID,
  input  logic              srcB_useID,
  input  logic [ADDR_W-1:0] dst_addrEX,
  input  logic              weEX,
  input  logic              mem_reEX,
  input  logic              branch_takenEX,
  input  logic              mem_reqMEM,
  input  logic              hltID,
  input  logic              hltWB,
  output logic              stallPC,
  output logic              stallIF,
  output logic              stallID,
  output logic              stallEX,
  output logic              flushIF,
  output logic              flushID,
  output logic              flushMEM,
  output logic              flushEX,
  output logic              halted
);

  localparam bit MEM_STALLS = (MEM_LAT != 0);
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'((MEM_LAT > 0) ? MEM_LAT - 1 : 0);

  hazState_t        stateReg, stateNext;
  logic [CNT_W-1:0] cntReg, cntNext;
  logic             haltPendReg, haltPendNext;
  logic             haltedReg;
  logic             loadUse;
  logic             memHold;
  pipeCtrl_t        ctrl;

  hazard_detect #(.ADDR_W(ADDR_W)) uDetect (
    .srcA    (srcA_ID),
    .srcAUse (srcA_useID),
    .srcB    (srcB_ID),
    .srcBUse (srcB_useID),
    .dstAddr (dst_addrEX),
    .we      (weEX),
    .memRe   (mem_reEX),
    .loadUse (loadUse)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg    <= RUN;
      cntReg      <= '0;
      haltPendReg <= 1'b0;
      haltedReg   <= 1'b0;
    end else begin
      stateReg    <= stateNext;
      cntReg      <= cntNext;
      haltPendReg <= haltPendNext;
      haltedReg   <= (stateNext == HALTED);
    end
  end

  always_comb begin
    stateNext    = stateReg;
    cntNext      = cntReg;
    haltPendNext = haltPendReg;
    ctrl         = '0;
    memHold      = (stateReg == RUN && mem_reqMEM && MEM_STALLS) ||
                   (stateReg == MEM_WAIT && cntReg != '0);

    // The exit cycle of MEM_WAIT never samples a new request.
    case (stateReg)
      RUN: begin
        if (hltWB) begin
          stateNext = HALTED;
        end else if (mem_reqMEM && MEM_STALLS) begin
          stateNext = MEM_WAIT;
          cntNext   = LAT_M1;
        end
      end
      MEM_WAIT: begin
        if (cntReg != '0) cntNext = cntReg - CNT_W'(1);
        else              stateNext = RUN;
      end
      HALTED:  stateNext = HALTED;
      default: stateNext = RUN;
    endcase

    if (stateReg == HALTED) begin
      ctrl.stallPC = 1'b1;
      ctrl.stallIF = 1'b1;
      ctrl.stallID = 1'b1;
      ctrl.stallEX = 1'b1;
    end else if (memHold) begin
      ctrl.stallPC  = 1'b1;
      ctrl.stallIF  = 1'b1;
      ctrl.stallID  = 1'b1;
      ctrl.stallEX  = 1'b1;
      ctrl.flushMEM = 1'b1;
    end else begin
      if (branch_takenEX) begin
        ctrl.flushIF = 1'b1;
        ctrl.flushID = 1'b1;
      end else if (loadUse) begin
        ctrl.stallPC = 1'b1;
        ctrl.stallIF = 1'b1;
        ctrl.stallID = 1'b1;
        ctrl.flushID = 1'b1;
      end
      // A pending halt stops fetch until the halt reaches WB.
      if (haltPendReg) begin
        ctrl.stallPC = 1'b1;
        ctrl.flushIF = 1'b1;
      end
      if (hltID && !branch_takenEX && !haltPendReg) haltPendNext = 1'b1;
    end

    if (rst) ctrl = '0;
  end

  assign stallPC  = ctrl.stallPC;
  assign stallIF  = ctrl.stallIF;
  assign stallID  = ctrl.stallID;
  assign stallEX  = ctrl.stallEX;
  assign flushIF  = ctrl.flushIF;
  assign flushID  = ctrl.flushID;
  assign flushEX  = ctrl.flushEX;
  assign flushMEM = ctrl.flushMEM;
  assign halted   = haltedReg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios against fixed expectations,
// then randomized traffic against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int MEM_LAT = 2;
  localparam int ADDR_W  = 4;
  localparam int CNT_W   = 4;

  // {stallPC,stallIF,stallID,stallEX,flushIF,flushID,flushEX,flushMEM,halted}
  localparam logic [8:0] IDLE = 9'b000000000;
  localparam logic [8:0] HOLD = 9'b111100010;
  localparam logic [8:0] BR   = 9'b000011000;
  localparam logic [8:0] LU   = 9'b111001000;
  localparam logic [8:0] HP   = 9'b100010000;
  localparam logic [8:0] HLT  = 9'b111100001;

  logic clk = 1'b0;
  logic rst;
  logic [ADDR_W-1:0] srcA_ID, srcB_ID, dst_addrEX;
  logic srcA_useID, srcB_useID, weEX, mem_reEX, branch_takenEX, mem_reqMEM, hltID, hltWB;
  logic stallPC, stallIF, stallID, stallEX, flushIF, flushID, flushMEM, flushEX, halted;
  logic [8:0] outs;

  int checks = 0;
  int errors = 0;

  // Model of the memory wait: holds still owed, and the one dead exit cycle.
  int holdsLeft;
  bit inExit;

  always #5 clk = ~clk;

  assign outs = {stallPC, stallIF, stallID, stallEX, flushIF, flushID, flushEX, flushMEM, halted};

  pipe_hazard_ctrl #(.MEM_LAT(MEM_LAT), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .srcA_ID(srcA_ID), .srcA_useID(srcA_useID),
    .srcB_ID(srcB_ID), .srcB_useID(srcB_useID),
    .dst_addrEX(dst_addrEX), .weEX(weEX), .mem_reEX(mem_reEX),
    .branch_takenEX(branch_takenEX), .mem_reqMEM(mem_reqMEM),
    .hltID(hltID), .hltWB(hltWB),
    .stallPC(stallPC), .stallIF(stallIF), .stallID(stallID), .stallEX(stallEX),
    .flushIF(flushIF), .flushID(flushID), .flushMEM(flushMEM), .flushEX(flushEX),
    .halted(halted)
  );

  task automatic clearInputs();
    srcA_ID = '0; srcB_ID = '0; dst_addrEX = '0;
    srcA_useID = 0; srcB_useID = 0; weEX = 0; mem_reEX = 0;
    branch_takenEX = 0; mem_reqMEM = 0; hltID = 0; hltWB = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    clearInputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clearInputs();
    mem_reqMEM = 1; branch_takenEX = 1; hltID = 1; hltWB = 1;
    mem_reEX = 1; weEX = 1; dst_addrEX = 4'd2; srcA_ID = 4'd2; srcA_useID = 1;
    rst = 1'b1;
    #1;
    checks++;
    if (outs !== IDLE) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=%b", outs, IDLE);
    end
    tick();
    clearInputs();
    rst = 1'b0;
    #1;
    checks++;
    if (outs !== IDLE) begin
      errors++;
      $display("FAIL reset_release got=%b want=%b", outs, IDLE);
    end
    $display("test_reset done");
  endtask

  task automatic test_mem_wait();
    logic expStallEx [6] = '{1, 1, 0, 1, 1, 0};
    doReset();
    mem_reqMEM = 1;
    #1;
    checks++;
    if (outs !== HOLD) begin errors++; $display("FAIL mem_first got=%b want=%b", outs, HOLD); end
    tick();
    mem_reqMEM = 0;
    #1;
    checks++;
    if (outs !== HOLD) begin errors++; $display("FAIL mem_second got=%b want=%b", outs, HOLD); end
    tick();
    checks++;
    if (outs !== IDLE) begin errors++; $display("FAIL mem_exit got=%b want=%b", outs, IDLE); end
    tick();
    checks++;
    if (outs !== IDLE) begin errors++; $display("FAIL mem_after got=%b want=%b", outs, IDLE); end
    $display("test_mem_wait single access done");
    // Back-to-back: request held high, each access costs MEM_LAT cycles.
    mem_reqMEM = 1;
    #1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (stallEX !== expStallEx[i] || flushMEM !== expStallEx[i]) begin
        errors++;
        $display("FAIL mem_b2b[%0d] stallEX=%b flushMEM=%b want=%b", i, stallEX, flushMEM, expStallEx[i]);
      end
      tick();
    end
    mem_reqMEM = 0;
    $display("test_back_to_back done");
  endtask

  task automatic test_load_use();
    doReset();
    mem_reEX = 1; weEX = 1; dst_addrEX = 4'd3;
    srcA_ID = 4'd5; srcA_useID = 1; srcB_ID = 4'd3; srcB_useID = 1;
    #1;
    checks++;
    if (outs !== LU) begin errors++; $display("FAIL lu_srcB got=%b want=%b", outs, LU); end
    tick();
    mem_reEX = 0;
    #1;
    checks++;
    if (outs !== IDLE) begin errors++; $display("FAIL lu_clear got=%b want=%b", outs, IDLE); end
    mem_reEX = 1; dst_addrEX = 4'd0; srcB_ID = 4'd0;
    #1;
    checks++;
    if (outs !== IDLE) begin errors++; $display("FAIL lu_r0 got=%b want=%b", outs, IDLE); end
    dst_addrEX = 4'd5; srcA_useID = 0; srcB_ID = 4'd1;
    #1;
    checks++;
    if (outs !== IDLE) begin errors++; $display("FAIL lu_unused got=%b want=%b", outs, IDLE); end
    srcA_useID = 1;
    #1;
    checks++;
    if (outs !== LU) begin errors++; $display("FAIL lu_srcA got=%b want=%b", outs, LU); end
    branch_takenEX = 1;
    #1;
    checks++;
    if (outs !== BR) begin errors++; $display("FAIL branch_over_lu got=%b want=%b", outs, BR); end
    clearInputs();
    $display("test_load_use done");
  endtask

  task automatic test_branch_in_wait();
    doReset();
    mem_reqMEM = 1;
    #1;
    tick();
    mem_reqMEM = 0; branch_takenEX = 1;
    #1;
    checks++;
    if (outs !== HOLD) begin errors++; $display("FAIL br_wait got=%b want=%b", outs, HOLD); end
    tick();
    checks++;
    if (outs !== BR) begin errors++; $display("FAIL br_exit got=%b want=%b", outs, BR); end
    tick();
    branch_takenEX = 0;
    #1;
    checks++;
    if (outs !== IDLE) begin errors++; $display("FAIL br_after got=%b want=%b", outs, IDLE); end
    $display("test_branch_in_wait done");
  endtask

  task automatic test_halt();
    doReset();
    hltID = 1;
    #1;
    checks++;
    if (outs !== IDLE) begin errors++; $display("FAIL halt_decode got=%b want=%b", outs, IDLE); end
    tick();
    hltID = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) hltWB = 1;
      #1;
      checks++;
      if (outs !== HP) begin errors++; $display("FAIL halt_pend[%0d] got=%b want=%b", i, outs, HP); end
      tick();
    end
    hltWB = 0;
    for (int i = 0; i < 12; i++) begin
      mem_reqMEM = 1'($urandom); branch_takenEX = 1'($urandom);
      mem_reEX = 1; weEX = 1; dst_addrEX = 4'd2; srcA_ID = 4'd2; srcA_useID = 1;
      #1;
      checks++;
      if (outs !== HLT) begin errors++; $display("FAIL halted[%0d] got=%b want=%b", i, outs, HLT); end
      tick();
    end
    clearInputs();
    // Halt squashed by a simultaneous taken branch.
    doReset();
    hltID = 1; branch_takenEX = 1;
    tick();
    clearInputs();
    #1;
    checks++;
    if (outs !== IDLE) begin errors++; $display("FAIL halt_squash got=%b want=%b", outs, IDLE); end
    $display("test_halt done");
  endtask

  task automatic test_reset_mid_wait();
    doReset();
    mem_reqMEM = 1;
    tick();
    mem_reqMEM = 0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (outs !== IDLE) begin errors++; $display("FAIL rst_mid_wait got=%b want=%b", outs, IDLE); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (outs !== IDLE) begin errors++; $display("FAIL rst_after[%0d] got=%b want=%b", i, outs, IDLE); end
    end
    $display("test_reset_mid_wait done");
  endtask

  function automatic bit modelLoadUse();
    logic [ADDR_W-1:0] reads[$];
    if (srcA_useID) reads.push_back(srcA_ID);
    if (srcB_useID) reads.push_back(srcB_ID);
    if (!(mem_reEX && weEX) || dst_addrEX == 0) return 0;
    foreach (reads[k]) if (reads[k] == dst_addrEX) return 1;
    return 0;
  endfunction

  task automatic test_random();
    logic [8:0] exp;
    bit hold;
    doReset();
    holdsLeft = 0;
    inExit = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        #1;
        checks++;
        if (outs !== IDLE) begin errors++; $display("FAIL rand_rst cyc=%0d got=%b want=%b", cyc, outs, IDLE); end
        $display("cyc %0d reset", cyc);
        holdsLeft = 0;
        inExit = 0;
        tick();
        rst = 1'b0;
        continue;
      end
      srcA_ID = ADDR_W'($urandom_range(0, 3)); srcB_ID = ADDR_W'($urandom_range(0, 3));
      dst_addrEX = ADDR_W'($urandom_range(0, 3));
      srcA_useID = 1'($urandom); srcB_useID = 1'($urandom);
      weEX = 1'($urandom); mem_reEX = 1'($urandom);
      branch_takenEX = ($urandom_range(0, 5) == 0);
      mem_reqMEM = ($urandom_range(0, 3) == 0);
      #1;
      hold = (holdsLeft > 0) || (!inExit && mem_reqMEM && MEM_LAT > 0);
      if (hold)                exp = HOLD;
      else if (branch_takenEX) exp = BR;
      else if (modelLoadUse()) exp = LU;
      else                     exp = IDLE;
      checks++;
      if (outs !== exp) begin
        errors++;
        $display("FAIL rand cyc=%0d got=%b want=%b", cyc, outs, exp);
      end
      $display("cyc %0d req=%b br=%b out=%b", cyc, mem_reqMEM, branch_takenEX, outs);
      @(posedge clk);
      if (holdsLeft > 0) begin
        holdsLeft--;
        if (holdsLeft == 0) inExit = 1;
      end else if (inExit) begin
        inExit = 0;
      end else if (mem_reqMEM && MEM_LAT > 0) begin
        holdsLeft = MEM_LAT - 1;
        if (holdsLeft == 0) inExit = 1;
      end
      #1;
    end
    clearInputs();
    $display("test_random done");
  endtask

  initial begin
    rst = 1'b0;
    clearInputs();
    test_reset();
    test_mem_wait();
    test_load_use();
    test_branch_in_wait();
    test_halt();
    test_reset_mid_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
